// File: rtl/traffic_input_conditioner_if.sv
// Signal bundle between the raw front-panel inputs, the conditioner and traffic_light.
// master = conditioner (drives walk/sensor/walk_count), slave = the surrounding environment.
interface traffic_input_conditioner_if;
   logic       walk_btn;
   logic       sensor_raw;
   logic       walk_ack;
   logic       walk;
   logic       sensor;
   logic [7:0] walk_count;

   modport master (
      input  walk_btn,
      input  sensor_raw,
      input  walk_ack,
      output walk,
      output sensor,
      output walk_count
   );

   modport slave (
      output walk_btn,
      output sensor_raw,
      output walk_ack,
      input  walk,
      input  sensor,
      input  walk_count
   );
endinterface

// File: rtl/traffic_input_conditioner.sv
// Synchronise, debounce and condition the pedestrian button and vehicle sensor for traffic_light.
// Raw->walk 3+DEBOUNCE_CYCLES edges, raw->sensor 2+DEBOUNCE_CYCLES edges; no backpressure, walk held until walk_ack.
module traffic_input_conditioner #(
   parameter int DEBOUNCE_CYCLES    = 4,
   parameter int SENSOR_HOLD_CYCLES = 8
) (
   input logic                         clock,
   input logic                         reset,
   traffic_input_conditioner_if.master tic
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int HW = $clog2(SENSOR_HOLD_CYCLES + 1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(SENSOR_HOLD_CYCLES);
   localparam int CH_WALK   = 0;
   localparam int CH_SENSOR = 1;

   typedef enum logic [1:0] {IDLE, PENDING, SERVED} state_t;

   logic [1:0]    raw;
   logic [1:0]    sync1_q, sync2_q;
   logic [1:0]    deb_q, deb_d;
   logic [DW-1:0] cnt_q [2];
   logic [DW-1:0] cnt_d [2];
   logic [HW-1:0] hold_q, hold_d;
   logic          sensor_q, sensor_d;
   state_t        state_q;
   logic          walk_q;
   logic [7:0]    walk_count_q;

   assign raw = {tic.sensor_raw, tic.walk_btn};

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         deb_d[i] = deb_q[i];
         cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == DB_LAST) begin
               deb_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + DW'(1);
            end
         end
      end
   end

   // Sensor rises with the debounced level itself but falls only once the hold has run out,
   // so a re-detection inside the hold window reloads the counter without a gap.
   always_comb begin
      hold_d = '0;
      if (deb_q[CH_SENSOR]) begin
         hold_d = HOLD_LOAD;
      end else if (hold_q != '0) begin
         hold_d = hold_q - HW'(1);
      end
      sensor_d = deb_d[CH_SENSOR] | (hold_d != '0);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         deb_q    <= '0;
         cnt_q[0] <= '0;
         cnt_q[1] <= '0;
         hold_q   <= '0;
         sensor_q <= 1'b0;
      end else begin
         sync1_q  <= raw;
         sync2_q  <= sync1_q;
         deb_q    <= deb_d;
         cnt_q[0] <= cnt_d[0];
         cnt_q[1] <= cnt_d[1];
         hold_q   <= hold_d;
         sensor_q <= sensor_d;
      end
   end

   // SERVED waits for the button to be released, so a held press yields exactly one request.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         walk_q       <= 1'b0;
         walk_count_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (deb_q[CH_WALK]) begin
                  state_q      <= PENDING;
                  walk_q       <= 1'b1;
                  walk_count_q <= walk_count_q + 8'd1;
               end
            end
            PENDING: begin
               if (tic.walk_ack) begin
                  state_q <= SERVED;
                  walk_q  <= 1'b0;
               end
            end
            SERVED: begin
               if (!deb_q[CH_WALK]) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               walk_q  <= 1'b0;
            end
         endcase
      end
   end

   assign tic.walk       = walk_q;
   assign tic.sensor     = sensor_q;
   assign tic.walk_count = walk_count_q;
endmodule

// File: tb/tb_traffic_input_conditioner.sv
// Randomised and directed bench for traffic_input_conditioner against a behavioural reference model.
module tb_traffic_input_conditioner;
   localparam int D = 4;
   localparam int H = 8;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   traffic_input_conditioner_if bus();

   traffic_input_conditioner #(
      .DEBOUNCE_CYCLES    (D),
      .SENSOR_HOLD_CYCLES (H)
   ) dut (
      .clock (clock),
      .reset (reset),
      .tic   (bus)
   );

   always #5 clock = ~clock;

   // Reference model: edge-indexed raw history; a debounced level flips once the synchronised
   // value (raw delayed two edges) has disagreed with it for D consecutive edges.
   bit         raw_h [2][65536];
   int         n        = 0;
   bit         m_deb [2] = '{1'b0, 1'b0};
   bit         m_pending = 1'b0;
   bit         m_armed   = 1'b1;
   bit [7:0]   m_count   = 8'd0;
   bit         m_sensor  = 1'b0;
   int         last_one  = -100000;

   function automatic bit sync_at(input int ch, input int k);
      return (k - 2 >= 1) ? raw_h[ch][k-2] : 1'b0;
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         n         = 0;
         m_deb[0]  = 1'b0;
         m_deb[1]  = 1'b0;
         m_pending = 1'b0;
         m_armed   = 1'b1;
         m_count   = 8'd0;
         m_sensor  = 1'b0;
         last_one  = -100000;
      end else begin
         bit old_walk_deb;
         n = n + 1;
         raw_h[0][n] = bus.walk_btn;
         raw_h[1][n] = bus.sensor_raw;
         old_walk_deb = m_deb[0];
         for (int ch = 0; ch < 2; ch++) begin
            bit flip;
            flip = 1'b1;
            for (int k = n - D + 1; k <= n; k++)
               if (sync_at(ch, k) == m_deb[ch]) flip = 1'b0;
            if (flip) m_deb[ch] = !m_deb[ch];
         end
         if (m_pending) begin
            if (bus.walk_ack) begin
               m_pending = 1'b0;
               m_armed   = 1'b0;
            end
         end else if (!old_walk_deb) begin
            m_armed = 1'b1;
         end else if (m_armed) begin
            m_pending = 1'b1;
            m_armed   = 1'b0;
            m_count   = m_count + 8'd1;
         end
         if (m_deb[1]) last_one = n;
         m_sensor = (n - last_one) <= H;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clock);
      chk("model_walk", bus.walk, m_pending);
      chk("model_sensor", bus.sensor, m_sensor);
      chk("model_count", bus.walk_count, m_count);
   endtask

   task automatic ticks(input int k);
      repeat (k) tick();
   endtask

   task automatic pulse_ack();
      bus.walk_ack = 1'b1;
      tick();
      bus.walk_ack = 1'b0;
   endtask

   task automatic wait_walk(input int budget);
      int t;
      t = 0;
      while (bus.walk !== 1'b1 && t < budget) begin
         tick();
         t++;
      end
      chk("walk_timeout", bus.walk, 1);
   endtask

   initial begin
      int zeros;
      int run_w;
      int run_s;
      bus.walk_btn   = 1'b1;
      bus.sensor_raw = 1'b1;
      bus.walk_ack   = 1'b0;

      // Reset held with both inputs active
      repeat (3) begin
         tick();
         chk("rst_walk", bus.walk, 0);
         chk("rst_sensor", bus.sensor, 0);
         chk("rst_count", bus.walk_count, 0);
      end
      reset = 1'b1;
      ticks(5);
      chk("rel_sensor_e5", bus.sensor, 0);
      tick();
      chk("rel_sensor_e6", bus.sensor, 1);
      chk("rel_walk_e6", bus.walk, 0);
      tick();
      chk("rel_walk_e7", bus.walk, 1);
      chk("rel_count", bus.walk_count, 1);

      // Handshake with button still held
      pulse_ack();
      chk("ack_walk", bus.walk, 0);
      ticks(5);
      chk("held_walk", bus.walk, 0);
      bus.walk_btn = 1'b0;
      ticks(10);
      bus.walk_btn = 1'b1;
      ticks(6);
      chk("repress_e6", bus.walk, 0);
      tick();
      chk("repress_e7", bus.walk, 1);
      chk("repress_count", bus.walk_count, 2);

      // Fresh press edge together with ack while pending: ack wins
      bus.walk_btn = 1'b0;
      ticks(8);
      bus.walk_btn = 1'b1;
      pulse_ack();
      chk("simul_walk", bus.walk, 0);
      bus.walk_btn = 1'b0;
      ticks(10);
      pulse_ack();
      ticks(2);
      chk("idle_ack_walk", bus.walk, 0);
      chk("idle_ack_count", bus.walk_count, 2);

      // Sensor stretch after a long detection
      bus.sensor_raw = 1'b0;
      zeros = 0;
      for (int i = 0; i < 13; i++) begin
         tick();
         if (bus.sensor !== 1'b1) zeros++;
      end
      chk("hold_gap", zeros, 0);
      tick();
      chk("hold_fall_e14", bus.sensor, 0);
      ticks(4);
      bus.sensor_raw = 1'b1;
      ticks(5);
      chk("rise_e5", bus.sensor, 0);
      tick();
      chk("rise_e6", bus.sensor, 1);
      ticks(4);
      bus.sensor_raw = 1'b0;
      ticks(5);
      bus.sensor_raw = 1'b1;
      zeros = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (bus.sensor !== 1'b1) zeros++;
      end
      chk("redetect_gap", zeros, 0);
      bus.sensor_raw = 1'b0;
      ticks(20);

      // Bounce rejection then a steady press
      repeat (5) begin
         bus.walk_btn = 1'b1;
         ticks(3);
         bus.walk_btn = 1'b0;
         ticks(2);
      end
      chk("bounce_walk", bus.walk, 0);
      chk("bounce_count", bus.walk_count, 2);
      bus.walk_btn = 1'b1;
      ticks(6);
      chk("steady_e6", bus.walk, 0);
      tick();
      chk("steady_e7", bus.walk, 1);
      chk("steady_count", bus.walk_count, 3);
      pulse_ack();
      bus.walk_btn = 1'b0;
      ticks(10);

      // Random traffic
      run_w = 0;
      run_s = 0;
      for (int i = 0; i < 4000; i++) begin
         if (run_w == 0) begin
            bus.walk_btn = 1'($urandom_range(0, 1));
            run_w = $urandom_range(1, 10);
         end
         if (run_s == 0) begin
            bus.sensor_raw = 1'($urandom_range(0, 1));
            run_s = $urandom_range(1, 16);
         end
         bus.walk_ack = ($urandom_range(0, 5) == 0);
         run_w--;
         run_s--;
         tick();
      end
      bus.walk_ack = 1'b0;

      // Asynchronous reset while a request is pending
      bus.walk_btn   = 1'b0;
      bus.sensor_raw = 1'b1;
      ticks(10);
      pulse_ack();
      bus.walk_btn = 1'b0;
      ticks(10);
      bus.walk_btn = 1'b1;
      wait_walk(20);
      @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      chk("async_walk", bus.walk, 0);
      chk("async_sensor", bus.sensor, 0);
      chk("async_count", bus.walk_count, 0);
      ticks(3);
      reset = 1'b1;
      ticks(6);
      chk("post_rst_e6", bus.walk, 0);
      tick();
      chk("post_rst_e7", bus.walk, 1);
      chk("post_rst_count", bus.walk_count, 1);

      // 255 further accepted presses bring the count back round to zero
      pulse_ack();
      for (int i = 0; i < 255; i++) begin
         bus.walk_btn = 1'b0;
         ticks(8);
         bus.walk_btn = 1'b1;
         wait_walk(12);
         pulse_ack();
      end
      chk("wrap_count", bus.walk_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
